multicycle_control: RTL and testbench

- Multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder with a registered FSM that sequences fetch, decode, execute, memory and writeback over several clocks.
- It adds a memory-ready wait handshake with a timeout, BNE, LW/SW and sticky fault flags.
- It sits between the instruction register (OP), the ALU (Zero), unified memory (MemReady) and the multi-cycle datapath muxes and enables.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit bus: instruction/status inputs from the datapath and the
// control strobes and selects driven back into it.
interface multicycle_control_if #(
  parameter int unsigned ALUOP_WIDTH = 3
);
  logic [5:0]             OP;
  logic                   Zero;
  logic                   MemReady;
  logic                   PCWrite;
  logic                   IorD;
  logic                   MemRead;
  logic                   MemWrite;
  logic                   IRWrite;
  logic                   MemtoReg;
  logic                   RegDst;
  logic                   RegWrite;
  logic                   ALUSrcA;
  logic [1:0]             ALUSrcB;
  logic [ALUOP_WIDTH-1:0] ALUOp;
  logic [1:0]             PCSrc;
  logic                   ExtendSide;
  logic [3:0]             State;
  logic                   IllegalOp;
  logic                   MemFault;

  modport master (
    input  OP, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, ExtendSide, State, IllegalOp, MemFault
  );

  modport slave (
    output OP, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSrc, ExtendSide, State, IllegalOp, MemFault
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with a bounded memory-ready wait and sticky illegal-opcode / timeout flags.
module multicycle_control #(
  parameter int unsigned ALUOP_WIDTH = 3,
  parameter int unsigned WAIT_LIMIT  = 8
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);
  localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpBne  = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpOri  = 6'h0d;
  localparam logic [5:0] OpLui  = 6'h0f;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2b;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
    StMemWb  = 4'd4,  StMemWr  = 4'd5,  StExec   = 4'd6,  StAluWb  = 4'd7,
    StBranch = 4'd8,  StJump   = 4'd9,  StExecI  = 4'd10, StAluIWb = 4'd11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_set;
  logic             fault_q;
  logic             wait_st, timeout;
  logic [2:0]       alu_op;

  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout = wait_st && !bus.MemReady && (cnt_q == CNT_W'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_q | ill_set;
      fault_q <= fault_q | timeout;
    end
  end

  always_comb begin
    state_d = StFetch;
    cnt_d   = '0;
    ill_set = 1'b0;
    case (state_q)
      StFetch:  state_d = bus.MemReady ? StDecode : StFetch;
      StDecode: begin
        case (bus.OP)
          OpLw, OpSw:            state_d = StMemAdr;
          OpR:                   state_d = StExec;
          OpAddi, OpOri, OpLui:  state_d = StExecI;
          OpBeq, OpBne:          state_d = StBranch;
          OpJ:                   state_d = StJump;
          default: begin
            state_d = StFetch;
            ill_set = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        if (bus.OP == OpLw)      state_d = StMemRd;
        else if (bus.OP == OpSw) state_d = StMemWr;
        else                     state_d = StFetch;
      end
      StMemRd:  state_d = bus.MemReady ? StMemWb : StMemRd;
      StMemWr:  state_d = bus.MemReady ? StFetch : StMemWr;
      StExec:   state_d = StAluWb;
      StExecI:  state_d = StAluIWb;
      default:  state_d = StFetch;
    endcase
    // Counter only survives while stalled in a wait state; any exit clears it.
    if (wait_st && !bus.MemReady) cnt_d = cnt_q + CNT_W'(1);
    if (timeout) begin
      state_d = StFetch;
      cnt_d   = '0;
    end
  end

  always_comb begin
    bus.PCWrite    = 1'b0;
    bus.IorD       = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'd0;
    bus.PCSrc      = 2'd0;
    bus.ExtendSide = 1'b0;
    alu_op         = 3'b100;
    case (state_q)
      StFetch: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      StDecode: bus.ALUSrcB = 2'd3;
      StMemAdr: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
      end
      StMemRd: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
      end
      StMemWb: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      StMemWr: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      StExec: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = 3'b111;
      end
      StAluWb: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      StExecI: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'd2;
        alu_op         = (bus.OP == OpOri) ? 3'b101 : 3'b100;
        bus.ExtendSide = (bus.OP == OpLui);
      end
      StAluIWb: begin
        bus.RegWrite   = 1'b1;
        bus.ExtendSide = (bus.OP == OpLui);
      end
      StBranch: begin
        bus.ALUSrcA = 1'b1;
        alu_op      = 3'b110;
        bus.PCSrc   = 2'd1;
        bus.PCWrite = (bus.OP == OpBne) ? !bus.Zero : bus.Zero;
      end
      StJump: begin
        bus.PCSrc   = 2'd2;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
    // Outputs are forced low for the whole time reset is held.
    if (reset) begin
      bus.PCWrite    = 1'b0;
      bus.IorD       = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.MemtoReg   = 1'b0;
      bus.RegDst     = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ALUSrcA    = 1'b0;
      bus.ALUSrcB    = 2'd0;
      bus.PCSrc      = 2'd0;
      bus.ExtendSide = 1'b0;
      alu_op         = 3'b000;
    end
    bus.ALUOp = ALUOP_WIDTH'(alu_op);
  end

  assign bus.State     = reset ? 4'd0 : state_q;
  assign bus.IllegalOp = ill_q;
  assign bus.MemFault  = fault_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-path model checked every cycle,
// plus directed instruction runs with hand-written state/strobe traces.
module tb_multicycle_control;
  localparam int unsigned AW = 4;
  localparam int unsigned WL = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if #(.ALUOP_WIDTH(AW)) bus ();

  multicycle_control #(.ALUOP_WIDTH(AW), .WAIT_LIMIT(WL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] act_v;
  assign act_v = {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
                  bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
                  bus.ExtendSide, bus.State, bus.IllegalOp, bus.MemFault};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected control word for one cycle, straight from the per-state table.
  function automatic logic [23:0] model_out(input int st, input logic [5:0] op, input logic z,
                                            input logic mr, input bit ill, input bit flt);
    logic pcw = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
    logic ext = 0;
    logic [1:0] asb = 2'd0, pcs = 2'd0;
    logic [3:0] aop = 4'd4;
    case (st)
      0:  begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
      1:  asb = 2'd3;
      2:  begin asa = 1; asb = 2'd2; end
      3:  begin iord = 1; mrd = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mwr = 1; end
      6:  begin asa = 1; aop = 4'd7; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin asa = 1; aop = 4'd6; pcs = 2'd1; pcw = (op == 6'h05) ? !z : z; end
      9:  begin pcs = 2'd2; pcw = 1; end
      10: begin asa = 1; asb = 2'd2; aop = (op == 6'h0d) ? 4'd5 : 4'd4; ext = (op == 6'h0f); end
      11: begin rw = 1; ext = (op == 6'h0f); end
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs, ext, 4'(st), ill, flt};
  endfunction

  // Model: current step plus the queue of steps left in the instruction.
  int m_state = 0;
  int m_path[$];
  int m_waits = 0;
  bit m_ill = 0;
  bit m_fault = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", 64'(act_v), 64'd0);
      m_state = 0;
      m_path.delete();
      m_waits = 0;
      m_ill   = 0;
      m_fault = 0;
    end else begin
      chk("cycle_outputs", 64'(act_v),
          64'(model_out(m_state, bus.OP, bus.Zero, bus.MemReady, m_ill, m_fault)));
      if ((m_state == 0 || m_state == 3 || m_state == 5) && !bus.MemReady) begin
        m_waits++;
        if (m_waits == WL) begin
          m_fault = 1;
          m_waits = 0;
          m_state = 0;
          m_path.delete();
        end
      end else begin
        m_waits = 0;
        if (m_state == 0) begin
          m_state = 1;
        end else if (m_state == 1) begin
          case (bus.OP)
            6'h00:               m_path = '{6, 7};
            6'h02:               m_path = '{9};
            6'h04, 6'h05:        m_path = '{8};
            6'h08, 6'h0d, 6'h0f: m_path = '{10, 11};
            6'h23:               m_path = '{2, 3, 4};
            6'h2b:               m_path = '{2, 5};
            default:             m_path.delete();
          endcase
          if (m_path.size() == 0) begin
            m_ill   = 1;
            m_state = 0;
          end else begin
            m_state = m_path.pop_front();
          end
        end else if (m_path.size() > 0) begin
          m_state = m_path.pop_front();
        end else begin
          m_state = 0;
        end
      end
    end
  end

  // Run one instruction for n cycles; mr[i] is MemReady in cycle i.
  task automatic run(input string name, input logic [5:0] op, input logic z,
                     input logic [15:0] mr, input int n, input logic [63:0] exp_tr,
                     input logic [15:0] exp_pw, input logic [15:0] exp_rw);
    logic [63:0] tr = 64'd0;
    logic [15:0] pw = 16'd0;
    logic [15:0] rw = 16'd0;
    bus.OP   = op;
    bus.Zero = z;
    for (int i = 0; i < n; i++) begin
      bus.MemReady = mr[i];
      @(negedge clk);
      tr    = {tr[59:0], bus.State};
      pw[i] = bus.PCWrite;
      rw[i] = bus.RegWrite;
      @(posedge clk);
      #1;
    end
    chk({name, "_states"}, tr, exp_tr);
    chk({name, "_pcwrite"}, 64'(pw), 64'(exp_pw));
    chk({name, "_regwrite"}, 64'(rw), 64'(exp_rw));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    bus.OP       = 6'h00;
    bus.Zero     = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    chk("reset_hold", 64'(act_v), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    run("r_type", 6'h00, 1'b0, 16'hFFFF, 4, 64'h0167, 16'h0001, 16'h0008);
    run("lw_wait2", 6'h23, 1'b0, 16'h0067, 7, 64'h0123334, 16'h0001, 16'h0040);
    chk("lw_no_fault", 64'(bus.MemFault), 64'd0);
    run("beq_taken", 6'h04, 1'b1, 16'hFFFF, 3, 64'h018, 16'h0005, 16'h0000);
    run("bne_zero1", 6'h05, 1'b1, 16'hFFFF, 3, 64'h018, 16'h0001, 16'h0000);
    run("bne_zero0", 6'h05, 1'b0, 16'hFFFF, 3, 64'h018, 16'h0005, 16'h0000);
    run("lui", 6'h0f, 1'b0, 16'hFFFF, 4, 64'h01AB, 16'h0001, 16'h0008);
    run("ori", 6'h0d, 1'b0, 16'hFFFF, 4, 64'h01AB, 16'h0001, 16'h0008);
    run("jump", 6'h02, 1'b0, 16'hFFFF, 3, 64'h019, 16'h0005, 16'h0000);
    run("sw", 6'h2b, 1'b0, 16'hFFFF, 4, 64'h0125, 16'h0001, 16'h0000);
    run("fetch_wait1", 6'h00, 1'b0, 16'h001E, 5, 64'h00167, 16'h0002, 16'h0010);

    run("sw_timeout", 6'h2b, 1'b0, 16'h0007, 7, 64'h0125555, 16'h0001, 16'h0000);
    chk("sw_timeout_fault", 64'(bus.MemFault), 64'd1);
    run("after_timeout", 6'h00, 1'b0, 16'hFFFF, 4, 64'h0167, 16'h0001, 16'h0008);
    chk("fault_sticky", 64'(bus.MemFault), 64'd1);

    // Async reset in the middle of an R-type, away from any clock edge.
    bus.OP       = 6'h00;
    bus.MemReady = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_reset_exec", 64'(bus.State), 64'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 64'(act_v), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("fault_cleared", 64'(bus.MemFault), 64'd0);

    run("fetch_timeout", 6'h00, 1'b0, 16'h00F0, 8, 64'h00000167, 16'h0010, 16'h0080);
    chk("fetch_timeout_fault", 64'(bus.MemFault), 64'd1);

    run("illegal", 6'h3f, 1'b0, 16'hFFFF, 2, 64'h01, 16'h0001, 16'h0000);
    chk("illegal_flag", 64'(bus.IllegalOp), 64'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("illegal_cleared", 64'(bus.IllegalOp), 64'd0);
    run("post_reset_r", 6'h00, 1'b0, 16'hFFFF, 4, 64'h0167, 16'h0001, 16'h0008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
